// File: rtl/tt_uart_tx_pkg.sv
// tt_uart_pkg: shared types and constants for the tt_uart transmit/receive
// slice.
//   uart_state_t    - serialiser FSM state encoding
//   UART_DATA_BITS  - payload bits per frame
//   UART_FRAME_BITS - total bits per frame (start + data + [parity] + stop)
// Optional feature macro: TT_UART_TX_PARITY_EN (adds an even-parity bit).
package tt_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int UART_DATA_BITS = 8;

`ifdef TT_UART_TX_PARITY_EN
    localparam int UART_FRAME_BITS = 11;
`else
    localparam int UART_FRAME_BITS = 10;
`endif

endpackage

// File: rtl/tt_uart_tx_if.sv
// tt_uart_tx_if: byte valid/ready handshake between the project core and
// the UART transmitter.
//   data_in - byte to transmit (source -> sink)
//   valid   - data_in is presented (source -> sink)
//   ready   - sink can accept a byte (sink -> source)
// A byte transfers on any rising clock edge with valid && ready.
interface tt_uart_tx_if;

    logic [7:0] data_in;
    logic       valid;
    logic       ready;

    modport master (
        output data_in,
        output valid,
        input  ready
    );

    modport slave (
        input  data_in,
        input  valid,
        output ready
    );

endinterface

// File: rtl/tt_uart_tx_fifo.sv
// tt_uart_fifo: parameterised synchronous circular-buffer FIFO, shared by
// the UART transmit and receive paths.
//   clk, rst - clock, asynchronous active-high reset (empties the FIFO)
//   wr_en    - push wr_data (ignored while full)
//   wr_data  - data to push
//   rd_en    - pop the head (ignored while empty)
//   rd_data  - current head entry (valid while !empty)
//   full     - count == DEPTH
//   empty    - count == 0
//   count    - number of stored entries
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module tt_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leave the count unchanged.
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/tt_uart_tx.sv
// tt_uart_tx: byte-serialising UART transmitter. Bytes enter through a
// valid/ready handshake into a small FIFO and leave on tx as 8N1 frames
// (8E1 with TT_UART_TX_PARITY_EN defined), LSB first, CLK_DIV clocks/bit.
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset (drops queued bytes, tx high)
//   in_if - tt_uart_tx_if.slave: data_in, valid in; ready out (= !full)
//   tx    - serial line, idles high
//   busy  - a frame is in flight or the FIFO holds bytes
// Parameters: CLK_DIV (2..255), FIFO_DEPTH (power of two, >= 2).
// Optional feature macro: TT_UART_TX_PARITY_EN.
module tt_uart_tx #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    tt_uart_tx_if.slave  in_if,
    output logic         tx,
    output logic         busy
);

    import tt_uart_pkg::*;

    localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int                BAUD_W    = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

    uart_state_t                          state;
    uart_state_t                          state_next;
    logic        [BAUD_W-1:0]             baud;
    logic        [2:0]                    bit_cnt;
    logic        [UART_DATA_BITS-1:0]     shift;
    logic                                 baud_tc;
    logic                                 last_bit;
    logic                                 pop;
    logic        [UART_DATA_BITS-1:0]     fifo_rd_data;
    logic                                 fifo_full;
    logic                                 fifo_empty;
    logic        [CNT_W-1:0]              fifo_count;
`ifdef TT_UART_TX_PARITY_EN
    logic                                 parity_bit;
`endif

    tt_uart_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_if.valid && in_if.ready),
        .wr_data (in_if.data_in),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign in_if.ready = !fifo_full;
    assign busy        = (state != IDLE) || (fifo_count != '0);
    assign baud_tc     = (baud == BAUD_LAST);
    assign last_bit    = (bit_cnt == 3'(UART_DATA_BITS - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = START;
                end
            end
            START: begin
                if (baud_tc) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (baud_tc && last_bit) begin
`ifdef TT_UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef TT_UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tc) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                // Chain straight into the next START so frames are gapless.
                if (baud_tc) begin
                    state_next = fifo_empty ? IDLE : START;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: serial line and FIFO pop strobe
    always_comb begin
        tx  = 1'b1;
        pop = 1'b0;
        case (state)
            IDLE:    pop = !fifo_empty;
            START:   tx  = 1'b0;
            DATA:    tx  = shift[0];
`ifdef TT_UART_TX_PARITY_EN
            PARITY:  tx  = parity_bit;
`endif
            STOP:    pop = baud_tc && !fifo_empty;
            default: tx  = 1'b1;
        endcase
    end

    // Baud counter, bit counter and shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
`ifdef TT_UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            if ((state_next != state) || baud_tc || (state == IDLE)) begin
                baud <= '0;
            end else begin
                baud <= baud + 1'b1;
            end

            if (pop) begin
                shift   <= fifo_rd_data;
                bit_cnt <= '0;
`ifdef TT_UART_TX_PARITY_EN
                // Captured at load: the shift register is consumed by then.
                parity_bit <= ^fifo_rd_data;
`endif
            end else if ((state == DATA) && baud_tc) begin
                shift   <= {1'b0, shift[UART_DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule
